// File: rtl/mem_ctrl_pkg.sv
// Purpose: shared encodings for the memory-stage controller.
//   - op_e    : request opcodes carried on req_op (code 7 is reserved and
//               behaves like NOP)
//   - state_e : controller FSM states, also visible on dbg_state
//   - SP_INIT_DEF : stack pointer value after reset (empty stack, top slot)
package mem_ctrl_pkg;

  localparam int unsigned SP_INIT_DEF = 32'h0000_07FF;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_STORE  = 3'd2,
    OP_PUSH   = 3'd3,
    OP_POP    = 3'd4,
    OP_PUSH32 = 3'd5,
    OP_POP32  = 3'd6,
    OP_RSVD   = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BEAT0  = 3'd1,
    ST_BEAT1  = 3'd2,
    ST_RDWAIT = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/mem_stage_ctrl_sp_unit.sv
// Purpose: stack pointer register with its neighbour values and the
//   underflow check for pop requests.
// Ports:
//   clk, reset      : clock, synchronous active-low reset (sp -> SP_INIT)
//   commit          : apply the SP adjustment implied by commit_op this edge
//   commit_op       : opcode of the operation being completed
//   check_op        : opcode being offered for acceptance (underflow check)
//   sp, sp_p1, sp_p2, sp_m1 : SP and SP+1 / SP+2 / SP-1 (wrapping)
//   underflow       : check_op is a pop that would read past the empty stack
module sp_unit
  import mem_ctrl_pkg::*;
#(
  parameter int                ADDR_W  = 16,
  parameter logic [ADDR_W-1:0] SP_INIT = ADDR_W'(SP_INIT_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              commit,
  input  logic [2:0]        commit_op,
  input  logic [2:0]        check_op,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] sp_p1,
  output logic [ADDR_W-1:0] sp_p2,
  output logic [ADDR_W-1:0] sp_m1,
  output logic              underflow
);

  localparam logic [ADDR_W-1:0] SP_INIT_M1 = SP_INIT - ADDR_W'(1);

  logic [ADDR_W-1:0] sp_q;
  logic [ADDR_W-1:0] sp_m2;

  assign sp    = sp_q;
  assign sp_p1 = sp_q + ADDR_W'(1);
  assign sp_p2 = sp_q + ADDR_W'(2);
  assign sp_m1 = sp_q - ADDR_W'(1);
  assign sp_m2 = sp_q - ADDR_W'(2);

  // A 32-bit pop needs two occupied slots, so SP_INIT-1 is already too high.
  assign underflow = ((check_op == OP_POP)   && (sp_q == SP_INIT)) ||
                     ((check_op == OP_POP32) && (sp_q >= SP_INIT_M1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      sp_q <= SP_INIT;
    end else if (commit) begin
      case (commit_op)
        OP_PUSH:   sp_q <= sp_m1;
        OP_POP:    sp_q <= sp_p1;
        OP_PUSH32: sp_q <= sp_m2;
        OP_POP32:  sp_q <= sp_p2;
        default:   sp_q <= sp_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Purpose: initiator side of the Data_Memory port. Accepts load/store/stack
//   requests, sequences one or two memory beats, returns a one-cycle response.
//   32-bit stack ops (PUSH32/POP32) are split into two 16-bit beats.
// Ports:
//   clk, reset             : clock, synchronous active-low reset
//   req_valid/req_ready    : request handshake; a request is taken on an edge
//                            where both are 1. req_ready is 1 only in IDLE and
//                            the requester holds req_valid/op/addr/wdata stable
//                            until it is taken. req_valid while busy is ignored.
//   req_op/req_addr/req_wdata : opcode, LOAD/STORE address, write data
//   rsp_valid/rsp_data/rsp_err: one-cycle completion pulse, read result,
//                            stack-underflow flag (op dropped)
//   sp                     : current stack pointer
//   mem_*                  : Data_Memory port; read data returns one cycle
//                            after read_enable
//   dbg_state              : current FSM state (state_e encoding)
module mem_stage_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int                ADDR_W  = 16,
  parameter int                DATA_W  = 16,
  parameter logic [ADDR_W-1:0] SP_INIT = ADDR_W'(SP_INIT_DEF)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [2*DATA_W-1:0] rsp_data,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   sp,
  output logic                mem_read_enable,
  output logic                mem_write_enable,
  output logic [ADDR_W-1:0]   mem_read_addr,
  output logic [ADDR_W-1:0]   mem_write_addr,
  output logic [DATA_W-1:0]   mem_write_data,
  input  logic [DATA_W-1:0]   mem_read_data,
  output logic [2:0]          dbg_state
);

  state_e              state_q;
  op_e                 op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2*DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0]   lo_q;
  logic                err_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic [2*DATA_W-1:0] rsp_data_q;
  logic                rsp_err_q;
  logic                mem_re_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_raddr_q;
  logic [ADDR_W-1:0]   mem_waddr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  op_e                 req_op_e;
  logic                sp_commit;
  logic                underflow;
  logic [ADDR_W-1:0]   sp_p1;
  logic [ADDR_W-1:0]   sp_p2;
  logic [ADDR_W-1:0]   sp_m1;

  assign req_op_e  = op_e'(req_op);
  // SP moves only when a successful stack op completes.
  assign sp_commit = (state_q == ST_RESP) && !err_q;

  sp_unit #(
    .ADDR_W  (ADDR_W),
    .SP_INIT (SP_INIT)
  ) u_sp (
    .clk       (clk),
    .reset     (reset),
    .commit    (sp_commit),
    .commit_op (op_q),
    .check_op  (req_op),
    .sp        (sp),
    .sp_p1     (sp_p1),
    .sp_p2     (sp_p2),
    .sp_m1     (sp_m1),
    .underflow (underflow)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_NOP;
      addr_q      <= '0;
      wdata_q     <= '0;
      lo_q        <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_raddr_q <= '0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      // Enables and the response pulse are single-cycle by default.
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid && (req_op_e != OP_NOP) && (req_op_e != OP_RSVD)) begin
            op_q        <= req_op_e;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            err_q       <= underflow;
            // An underflowing pop skips memory entirely.
            state_q     <= underflow ? ST_RESP : ST_BEAT0;
          end
        end
        ST_BEAT0: begin
          state_q <= ST_RESP;
          case (op_q)
            OP_LOAD: begin
              mem_re_q    <= 1'b1;
              mem_raddr_q <= addr_q;
              state_q     <= ST_RDWAIT;
            end
            OP_STORE: begin
              mem_we_q    <= 1'b1;
              mem_waddr_q <= addr_q;
              mem_wdata_q <= wdata_q[DATA_W-1:0];
            end
            OP_PUSH: begin
              mem_we_q    <= 1'b1;
              mem_waddr_q <= sp;
              mem_wdata_q <= wdata_q[DATA_W-1:0];
            end
            OP_POP: begin
              mem_re_q    <= 1'b1;
              mem_raddr_q <= sp_p1;
              state_q     <= ST_RDWAIT;
            end
            OP_PUSH32: begin
              mem_we_q    <= 1'b1;
              mem_waddr_q <= sp;
              mem_wdata_q <= wdata_q[2*DATA_W-1:DATA_W];
              state_q     <= ST_BEAT1;
            end
            OP_POP32: begin
              mem_re_q    <= 1'b1;
              mem_raddr_q <= sp_p1;
              state_q     <= ST_BEAT1;
            end
            default: state_q <= ST_RESP;
          endcase
        end
        ST_BEAT1: begin
          state_q <= ST_RESP;
          if (op_q == OP_PUSH32) begin
            mem_we_q    <= 1'b1;
            mem_waddr_q <= sp_m1;
            mem_wdata_q <= wdata_q[DATA_W-1:0];
          end else if (op_q == OP_POP32) begin
            mem_re_q    <= 1'b1;
            mem_raddr_q <= sp_p2;
            state_q     <= ST_RDWAIT;
          end
        end
        ST_RDWAIT: begin
          // For POP32 the low word (first read beat) is on the bus now;
          // single reads and the POP32 high word are taken in RESP.
          if (op_q == OP_POP32) lo_q <= mem_read_data;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= err_q;
          if (err_q) begin
            rsp_data_q <= '0;
          end else if (op_q == OP_POP32) begin
            rsp_data_q <= {mem_read_data, lo_q};
          end else if ((op_q == OP_LOAD) || (op_q == OP_POP)) begin
            rsp_data_q <= {{DATA_W{1'b0}}, mem_read_data};
          end else begin
            rsp_data_q <= '0;
          end
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          req_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready        = req_ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_data         = rsp_data_q;
  assign rsp_err          = rsp_err_q;
  assign mem_read_enable  = mem_re_q;
  assign mem_write_enable = mem_we_q;
  assign mem_read_addr    = mem_raddr_q;
  assign mem_write_addr   = mem_waddr_q;
  assign mem_write_data   = mem_wdata_q;
  assign dbg_state        = state_q;

endmodule
